// File: rtl/gpu_pkg.sv
// Shared core-state encoding and sizing helpers for the scheduler, ALUs, LSUs and dispatcher.
package gpu_pkg;

  // Encoding is consumed by the lane units; do not reorder.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } core_state_t;

  function automatic int THREAD_CNT_W(input int threads);
    return $clog2(threads) + 1;
  endfunction

endpackage

// File: rtl/core_scheduler_thread_mask_gen.sv
// Converts an active-lane count into a low-order fill mask; counts above the lane total saturate.
module thread_mask_gen
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic [THREAD_CNT_W(THREADS_PER_BLOCK)-1:0] thread_count,
  output logic [THREADS_PER_BLOCK-1:0]               mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      mask[i] = (int'(thread_count) > i);
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer driving the shared core_state bus and the block PC.
// Optional lane-PC divergence detection is built when DIVERGENCE_CHECK_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for dispatcher start; lane mask latched on launch
//   FETCH   | waiting for fetcher to return instruction at current_pc
//   DECODE  | decoder works on fetched instruction
//   REQUEST | LSUs issue memory requests
//   WAIT    | stalled until every active lane's LSU is idle
//   EXECUTE | ALUs compute, result registered at end of cycle
//   UPDATE  | RET retires block, else PC advances from lane 0
//   DONE    | done asserted until dispatcher drops start
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [THREAD_CNT_W(THREADS_PER_BLOCK)-1:0] thread_count,
  input  logic                                      fetch_done,
  input  logic                                      decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0]              lsu_busy,
  input  logic [THREADS_PER_BLOCK*PC_WIDTH-1:0]     next_pc,
  output core_state_t                               core_state,
  output logic [PC_WIDTH-1:0]                       current_pc,
  output logic                                      done,
  output logic                                      diverged
);

  core_state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic                         done_q, done_d;
  logic                         div_q, div_d;
  logic [THREADS_PER_BLOCK-1:0] mask_q, mask_d;
  logic [THREADS_PER_BLOCK-1:0] mask_new;
  logic [PC_WIDTH-1:0]          lane0_pc;
  logic                         lane_mismatch;

  thread_mask_gen #(
    .THREADS_PER_BLOCK(THREADS_PER_BLOCK)
  ) u_mask_gen (
    .thread_count(thread_count),
    .mask        (mask_new)
  );

  assign lane0_pc = next_pc[PC_WIDTH-1:0];

`ifdef DIVERGENCE_CHECK_EN
  always_comb begin
    lane_mismatch = 1'b0;
    for (int i = 1; i < THREADS_PER_BLOCK; i++) begin
      if (mask_q[i] && (next_pc[i*PC_WIDTH +: PC_WIDTH] != lane0_pc)) begin
        lane_mismatch = 1'b1;
      end
    end
  end
`else
  logic unused_lane_pcs;
  assign unused_lane_pcs = ^next_pc[THREADS_PER_BLOCK*PC_WIDTH-1:PC_WIDTH];
  assign lane_mismatch   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    div_d   = div_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          mask_d  = mask_new;
          div_d   = 1'b0;
        end
      end
      FETCH: begin
        if (fetch_done) state_d = DECODE;
      end
      DECODE:  state_d = REQUEST;
      REQUEST: state_d = WAIT;
      WAIT: begin
        if (~|(lsu_busy & mask_q)) state_d = EXECUTE;
      end
      EXECUTE: state_d = UPDATE;
      UPDATE: begin
        if (decoded_ret) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (lane_mismatch) begin
          // Lanes disagree on the next PC: stop rather than silently follow lane 0.
          state_d = DONE;
          done_d  = 1'b1;
          div_d   = 1'b1;
        end else begin
          state_d = FETCH;
          pc_d    = lane0_pc;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
          pc_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      div_q   <= div_d;
      mask_q  <= mask_d;
    end
  end

  assign core_state = state_q;
  assign current_pc = pc_q;
  assign done       = done_q;
  assign diverged   = div_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: randomized programs against a per-instruction timing model.
module tb_core_scheduler;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  thread_count;
  logic        fetch_done;
  logic        decoded_ret;
  logic [3:0]  lsu_busy;
  logic [31:0] next_pc;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        done;
  logic        diverged;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  bit exp_div = 1'b0;
  bit force_busy = 1'b0;
  bit busy_inact = 1'b0;

  always #5 clk = ~clk;

  core_scheduler #(
    .THREADS_PER_BLOCK(4),
    .PC_WIDTH         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .thread_count(thread_count),
    .fetch_done  (fetch_done),
    .decoded_ret (decoded_ret),
    .lsu_busy    (lsu_busy),
    .next_pc     (next_pc),
    .core_state  (core_state),
    .current_pc  (current_pc),
    .done        (done),
    .diverged    (diverged)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected state t cycles into an instruction with fd fetch stalls and bw busy WAIT cycles.
  function automatic logic [2:0] exp_state(input int t, input int fd, input int bw);
    if (t <= fd)          return S_FETCH;
    if (t == fd + 1)      return S_DECODE;
    if (t == fd + 2)      return S_REQUEST;
    if (t <= fd + 3 + bw) return S_WAIT;
    if (t == fd + 4 + bw) return S_EXECUTE;
    return S_UPDATE;
  endfunction

  task automatic run_instr(input logic [3:0] mask, input int fd, input int bw,
                           input logic [31:0] npc, input bit ret, input bit rst_mid,
                           input logic [7:0] exp_pc, output bit aborted);
    int len;
    logic [3:0] act;
    logic [3:0] sub;
    len = fd + bw + 6;
    aborted = 1'b0;
    sub = 4'($urandom) & mask;
    if (sub == 4'h0 || force_busy) sub = mask;
    for (int t = 0; t < len; t++) begin
      fetch_done = (t >= fd);
      if (t >= fd + 3 && t < fd + 3 + bw) act = sub;
      else if (t == fd + 3 + bw)          act = 4'h0;
      else                                act = 4'($urandom);
      lsu_busy    = (act & mask) | ((busy_inact ? 4'hF : 4'($urandom)) & ~mask);
      decoded_ret = (t == len - 1) ? ret : 1'($urandom);
      next_pc     = npc;
      start       = 1'($urandom);
      check("state", core_state, exp_state(t, fd, bw));
      check("pc", current_pc, exp_pc);
      check("done_low", done, 1'b0);
      check("diverged_low", diverged, 1'b0);
      if (rst_mid && t == fd + 3) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", core_state, S_IDLE);
        check("rst_pc", current_pc, 8'h00);
        check("rst_done", done, 1'b0);
        @(posedge clk);
        #1;
        start   = 1'b0;
        rst_n   = 1'b1;
        aborted = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // kind: 0 random, 1 straight line, 2 PC wrap, 3 divergence, 4 reset mid-WAIT, 5 fetch/WAIT gating
  task automatic run_block(input logic [2:0] tc, input int n, input int kind);
    logic [3:0]  mask;
    logic [7:0]  pc;
    logic [7:0]  tgt;
    logic [31:0] npc;
    int fd, bw, l;
    bit ret, div, ab;
    force_busy = (kind == 4);
    busy_inact = (kind == 5);
    mask = (tc >= 3'd4) ? 4'hF : 4'((1 << tc) - 1);
    check("idle_state", core_state, S_IDLE);
    check("idle_diverged", diverged, exp_div);
    start = 1'b1;
    thread_count = tc;
    @(posedge clk);
    #1;
    thread_count = 3'($urandom);
    pc = 8'h00;
    for (int k = 0; k < n; k++) begin
      ret = (k == n - 1);
      fd  = $urandom_range(0, 3);
      bw  = (mask == 4'h0) ? 0 : $urandom_range(0, 3);
      tgt = 8'($urandom);
      case (kind)
        1: begin fd = 0; bw = 0; tgt = pc + 8'd1; end
        2: tgt = (k == 0) ? 8'hFF : pc + 8'd1;
        4: if (k == 1) bw = 3;
        5: begin
          fd = (k == 0) ? 10 : 0;
          bw = (k == 1) ? 5 : 0;
        end
        default: ;
      endcase
      npc = {4{tgt}};
      if (kind == 0 && $urandom_range(0, 3) == 0) begin
        l = $urandom_range(1, 3);
        npc[l*8 +: 8] = tgt ^ 8'h01;
      end
      for (int i = 0; i < 4; i++) begin
        if (!mask[i]) npc[i*8 +: 8] = 8'($urandom);
      end
      if (kind == 3) npc = {8'd9, 8'd7, 8'd5, 8'd5};
      div = 1'b0;
`ifdef DIVERGENCE_CHECK_EN
      for (int i = 1; i < 4; i++) begin
        if (mask[i] && npc[i*8 +: 8] != npc[7:0]) div = !ret;
      end
`endif
      run_instr(mask, fd, bw, npc, ret, (kind == 4 && k == 1), pc, ab);
      if (ab) begin
        exp_div = 1'b0;
        return;
      end
      if (ret || div) begin
        exp_div = div;
        start = 1'b1;
        check("end_state", core_state, S_DONE);
        check("end_done", done, 1'b1);
        check("end_pc", current_pc, pc);
        check("end_diverged", diverged, div);
        repeat (3) begin
          @(posedge clk);
          #1;
          check("hold_state", core_state, S_DONE);
          check("hold_done", done, 1'b1);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("release_state", core_state, S_IDLE);
        check("release_done", done, 1'b0);
        check("release_pc", current_pc, 8'h00);
        check("release_diverged", diverged, exp_div);
        return;
      end
      pc = npc[7:0];
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    thread_count = 3'd0;
    fetch_done   = 1'b0;
    decoded_ret  = 1'b0;
    lsu_busy     = 4'h0;
    next_pc      = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", core_state, S_IDLE);
    check("reset_pc", current_pc, 8'h00);
    check("reset_done", done, 1'b0);
    check("reset_diverged", diverged, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_block(3'd4, 2, 4);
    run_block(3'd4, 4, 1);
    run_block(3'd2, 3, 5);
    run_block(3'd4, 3, 2);
    run_block(3'd3, 2, 3);
    for (int b = 0; b < 12; b++) begin
      run_block(3'($urandom_range(0, 7)), $urandom_range(1, 5), 0);
    end
    check("final_state", core_state, S_IDLE);
    check("final_diverged", diverged, exp_div);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
